stream_length_finder: RTL



---
 rtl/stream_length_finder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/stream_length_finder.sv
// Streaming null-terminated string length finder.
// Words of CHARS characters arrive over a valid/ready handshake; lane 0 is the
// most significant character and is scanned first. The character count up to
// the first all-zero character is reported with a held result handshake, and
// saturates at 2^LEN_W-1 with a sticky overflow flag.
module stream_length_finder #(
  parameter int CHAR_W = 8,
  parameter int CHARS  = 8,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHARS*CHAR_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LEN_W-1:0]        length,
  output logic                    overflow,
  output logic                    len_valid,
  input  logic                    out_ready
);

  localparam int NZ_W  = $clog2(CHARS + 1);
  localparam int SUM_W = LEN_W + NZ_W;
  localparam logic [LEN_W-1:0] MAX_LEN = {LEN_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic               overflow_q, overflow_d;
  logic               len_valid_q, len_valid_d;

  logic               accept_s;
  logic               found_s;
  logic [NZ_W-1:0]    nz_s;
  logic [SUM_W-1:0]   sum_s;
  logic [LEN_W-1:0]   count_sat_s;
  logic               ovf_next_s;

  assign in_ready  = (state_q != HOLD);
  assign accept_s  = in_valid & in_ready;
  assign length    = length_q;
  assign overflow  = overflow_q;
  assign len_valid = len_valid_q;

  // Locate the first all-zero lane, scanning from the most significant character.
  always_comb begin
    found_s = 1'b0;
    nz_s    = NZ_W'(CHARS);
    for (int i = 0; i < CHARS; i++) begin
      if (!found_s && (in_data[(CHARS-i)*CHAR_W-1 -: CHAR_W] == {CHAR_W{1'b0}})) begin
        found_s = 1'b1;
        nz_s    = NZ_W'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Add this word's characters to the running count, saturating at the maximum length.
  always_comb begin
    sum_s = SUM_W'(count_q) + SUM_W'(nz_s);
    if (sum_s > SUM_W'(MAX_LEN)) begin
      count_sat_s = MAX_LEN;
      ovf_next_s  = 1'b1;
    end else begin
      count_sat_s = sum_s[LEN_W-1:0];
      ovf_next_s  = ovf_q;
    end
  end

  // Next-state and result logic; nothing moves unless a word or the result is transferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    length_d    = length_q;
    overflow_d  = overflow_q;
    len_valid_d = len_valid_q;
    case (state_q)
      IDLE, SCAN: begin
        if (accept_s) begin
          count_d = count_sat_s;
          ovf_d   = ovf_next_s;
          if (found_s) begin
            state_d     = HOLD;
            length_d    = count_sat_s;
            overflow_d  = ovf_next_s;
            len_valid_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          count_d     = {LEN_W{1'b0}};
          ovf_d       = 1'b0;
          overflow_d  = 1'b0;
          len_valid_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        count_d     = {LEN_W{1'b0}};
        ovf_d       = 1'b0;
        len_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= {LEN_W{1'b0}};
      ovf_q       <= 1'b0;
      length_q    <= {LEN_W{1'b0}};
      overflow_q  <= 1'b0;
      len_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      length_q    <= length_d;
      overflow_q  <= overflow_d;
      len_valid_q <= len_valid_d;
    end
  end

endmodule
